// File: rtl/inst_rom_loader.sv
// Instruction memory with a combinational fetch port and a sequential
// program-load engine (optional whole-memory clear, then a valid/ready
// word stream written at incrementing word addresses).
module inst_rom_loader #(
  parameter int ADDR_WIDTH     = 10,
  parameter bit CLEAR_ON_START = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce_i,
  input  logic [31:0]           addr_i,
  output logic [31:0]           inst_o,
  input  logic                  load_start_i,
  input  logic                  load_valid_i,
  input  logic [31:0]           load_data_i,
  input  logic                  load_last_i,
  output logic                  load_ready_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH:0]   load_count_o,
  output logic                  trunc_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_MAX = '1;

  typedef enum logic [1:0] {IDLE, CLEAR, LOAD} state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  accept;
  logic                  last_slot;
  logic                  exit_load;
  logic                  unused_addr_bits;

  // A word is taken whenever the engine sits in LOAD and the source offers one.
  assign accept    = (state == LOAD) && load_valid_i;
  assign last_slot = (wr_ptr == PTR_MAX);
  assign exit_load = accept && (load_last_i || last_slot);

  // Word index ignores the byte offset and any bits above the memory size,
  // so fetch addresses wrap modulo DEPTH words.
  assign rd_idx           = addr_i[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{addr_i[31:ADDR_WIDTH+2], addr_i[1:0]};

  // Same-cycle fetch; a busy memory returns 0 so the core sees a nop.
  assign inst_o = (ce_i && !busy_o) ? mem[rd_idx] : 32'h0;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state and state-decoded handshake outputs.
  always_comb begin
    state_next   = state;
    busy_o       = 1'b0;
    load_ready_o = 1'b0;
    case (state)
      IDLE: begin
        if (load_start_i) state_next = CLEAR_ON_START ? CLEAR : LOAD;
      end
      CLEAR: begin
        busy_o = 1'b1;
        if (clr_ptr == PTR_MAX) state_next = LOAD;
      end
      LOAD: begin
        busy_o       = 1'b1;
        load_ready_o = 1'b1;
        if (exit_load) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pointers, completion pulse, word count and sticky truncation flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      clr_ptr      <= '0;
      wr_ptr       <= '0;
      done_o       <= 1'b0;
      load_count_o <= '0;
      trunc_o      <= 1'b0;
    end else begin
      done_o <= exit_load;
      if (state == IDLE && load_start_i) begin
        clr_ptr <= '0;
        wr_ptr  <= '0;
        trunc_o <= 1'b0;
      end
      // Wraps back to 0 after the last index, ready for the next load.
      if (state == CLEAR) clr_ptr <= clr_ptr + 1'b1;
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (exit_load) begin
        load_count_o <= {1'b0, wr_ptr} + 1'b1;
        if (last_slot && !load_last_i) trunc_o <= 1'b1;
      end
    end
  end

  // Single write port shared by the clear sweep and the load stream;
  // writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == CLEAR)  mem[clr_ptr] <= 32'h0;
      else if (accept)     mem[wr_ptr]  <= load_data_i;
    end
  end

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader: a 16-word clearing instance and a
// 4-word non-clearing instance driven from one linear stimulus sequence.
module tb_inst_rom_loader;

  logic        clk;
  logic        rst;

  logic        a_ce, a_start, a_valid, a_last;
  logic [31:0] a_addr, a_data, a_inst;
  logic        a_ready, a_busy, a_done, a_trunc;
  logic [4:0]  a_count;

  logic        b_ce, b_start, b_valid, b_last;
  logic [31:0] b_addr, b_data, b_inst;
  logic        b_ready, b_busy, b_done, b_trunc;
  logic [2:0]  b_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n;

  logic [31:0] bv [6];

  inst_rom_loader #(.ADDR_WIDTH(4), .CLEAR_ON_START(1'b1)) dut_a (
    .clk(clk), .rst(rst), .ce_i(a_ce), .addr_i(a_addr), .inst_o(a_inst),
    .load_start_i(a_start), .load_valid_i(a_valid), .load_data_i(a_data),
    .load_last_i(a_last), .load_ready_o(a_ready), .busy_o(a_busy),
    .done_o(a_done), .load_count_o(a_count), .trunc_o(a_trunc)
  );

  inst_rom_loader #(.ADDR_WIDTH(2), .CLEAR_ON_START(1'b0)) dut_b (
    .clk(clk), .rst(rst), .ce_i(b_ce), .addr_i(b_addr), .inst_o(b_inst),
    .load_start_i(b_start), .load_valid_i(b_valid), .load_data_i(b_data),
    .load_last_i(b_last), .load_ready_o(b_ready), .busy_o(b_busy),
    .done_o(b_done), .load_count_o(b_count), .trunc_o(b_trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    bv[0] = 32'h11111111; bv[1] = 32'h22222222; bv[2] = 32'h33333333;
    bv[3] = 32'h44444444; bv[4] = 32'h55555555; bv[5] = 32'h66666666;

    rst = 1'b0;
    a_ce = 0; a_addr = 0; a_start = 0; a_valid = 1; a_data = 32'hAAAA5555; a_last = 0;
    b_ce = 0; b_addr = 0; b_start = 0; b_valid = 1; b_data = 32'hAAAA5555; b_last = 0;
    tick();
    tick();
    check("rst_busy",  a_busy,  0);
    check("rst_ready", a_ready, 0);
    check("rst_done",  a_done,  0);
    check("rst_count", a_count, 0);
    check("rst_trunc", a_trunc, 0);
    check("rst_b_ready", b_ready, 0);
    rst = 1'b1; a_valid = 0; b_valid = 0;

    // Clearing load on instance A
    a_start = 1;
    tick();
    a_start = 0;
    check("clr_busy", a_busy, 1);
    n = 0;
    while (!a_ready && n < 40) begin n++; tick(); end
    check("clr_cycles", n, 16);
    check("load_busy", a_busy, 1);

    // Stream three words with valid gaps
    a_valid = 1; a_data = 32'h34011100; tick();
    a_valid = 0; tick();
    a_valid = 1; a_data = 32'h34020020; tick();
    a_valid = 0; tick(); tick();
    check("no_early_done", a_done, 0);
    a_valid = 1; a_data = 32'h3403ff00; a_last = 1; tick();
    check("done_pulse", a_done, 1);
    check("count3", a_count, 3);
    check("idle_busy", a_busy, 0);
    check("idle_ready", a_ready, 0);
    a_last = 0; a_valid = 1; a_data = 32'hDEADBEEF; tick();
    check("done_one_cycle", a_done, 0);
    a_valid = 0;

    // Fetch path
    a_ce = 1;
    a_addr = 32'h0;  #1 check("fetch0", a_inst, 32'h34011100);
    a_addr = 32'h4;  #1 check("fetch4", a_inst, 32'h34020020);
    a_addr = 32'h8;  #1 check("fetch8", a_inst, 32'h3403ff00);
    a_addr = 32'hC;  #1 check("fetchC_idle_valid_ignored", a_inst, 32'h0);
    a_addr = 32'h41; #1 check("fetch_wrap", a_inst, 32'h34011100);
    a_addr = 32'h6;  #1 check("fetch_misalign", a_inst, 32'h34020020);
    a_ce = 0;        #1 check("ce_off", a_inst, 32'h0);

    // Overflow on instance B
    b_start = 1;
    tick();
    b_start = 0;
    check("b_ready_noclear", b_ready, 1);
    check("b_busy", b_busy, 1);
    for (int i = 0; i < 4; i++) begin
      b_valid = 1; b_data = bv[i]; tick();
    end
    check("b_done", b_done, 1);
    check("b_count4", b_count, 4);
    check("b_trunc", b_trunc, 1);
    check("b_idle", b_busy, 0);
    for (int i = 4; i < 6; i++) begin
      b_valid = 1; b_data = bv[i]; tick();
    end
    check("b_done_cleared", b_done, 0);
    check("b_trunc_sticky", b_trunc, 1);
    b_valid = 0;
    b_ce = 1;
    for (int i = 0; i < 4; i++) begin
      b_addr = 32'(i * 4);
      #1 check("b_fetch", b_inst, bv[i]);
    end
    b_start = 1;
    tick();
    b_start = 0;
    check("b_trunc_clr", b_trunc, 0);
    check("b_count_held", b_count, 4);

    // Reset mid-LOAD on instance A
    a_ce = 1; a_addr = 32'h0;
    a_start = 1;
    tick();
    a_start = 0;
    check("fetch_busy", a_inst, 32'h0);
    n = 0;
    while (!a_ready && n < 40) begin n++; tick(); end
    check("clr_cycles2", n, 16);
    a_valid = 1; a_data = 32'hCAFE0001; tick();
    a_data = 32'hCAFE0002; a_start = 1; tick();
    a_start = 0; a_valid = 0;
    check("start_ignored_busy", a_busy, 1);
    check("start_ignored_ready", a_ready, 1);
    rst = 0;
    tick();
    rst = 1;
    check("mid_rst_busy",  a_busy,  0);
    check("mid_rst_ready", a_ready, 0);
    check("mid_rst_done",  a_done,  0);
    check("mid_rst_count", a_count, 0);
    check("mid_rst_trunc", a_trunc, 0);
    a_addr = 32'h0; #1 check("mid_fetch0", a_inst, 32'hCAFE0001);
    a_addr = 32'h4; #1 check("mid_fetch4", a_inst, 32'hCAFE0002);
    a_addr = 32'h8; #1 check("mid_fetch8", a_inst, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
